// File: rtl/sym_phase_align.sv
// sym_phase_align: decimates a 4-samples-per-symbol stream (qualified by
// sam_clk_ena) to one symbol per 4 strobes at a selectable sampling phase.
// The phase is stepped by advance/retard pulses. Optionally, it is also
// stepped by a Gardner timing error detector, enabled by defining
// GARDNER_TED_EN. When GARDNER_TED_EN is undefined, ted_err is tied to 0.
//
// Output handshake: sym_valid is a 1-cycle pulse with no ready. sym_out
// carries the new symbol in the same cycle and holds it until the next pulse.
// The downstream consumer must accept every pulse.
module sym_phase_align #(
  parameter int WIDTH          = 18,
  parameter int PHASE_INIT     = 0,
  parameter int STROBE_TIMEOUT = 8,
  parameter int ACC_W          = 24,
  parameter int TED_THRESH     = 4096
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    sam_clk_ena,
  input  logic signed [WIDTH-1:0] sam_in,
  input  logic                    advance,
  input  logic                    retard,
  output logic signed [WIDTH-1:0] sym_out,
  output logic                    sym_valid,
  output logic [1:0]              sym_phase,
  output logic                    slip,
  output logic                    strobe_lost,
  output logic signed [WIDTH-1:0] ted_err
);

  localparam int WD_W = $clog2(STROBE_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(STROBE_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(STROBE_TIMEOUT - 1);

  // Pending phase-adjust slot, one entry deep
  typedef enum logic [1:0] {
    ADJ_NONE = 2'd0,
    ADJ_ADV  = 2'd1,
    ADJ_RET  = 2'd2
  } adj_t;

  adj_t            adj_q, adj_d, ext_req, apply, ted_req;
  logic [1:0]      sam_cnt;
  logic [1:0]      phase_d;
  logic [1:0]      mid_phase;
  logic            wrap;
  logic            decide;
  logic            ext_cmd;
  logic [WD_W-1:0] wd_cnt;

  assign decide    = sam_clk_ena && (sam_cnt == sym_phase);
  assign ext_cmd   = advance ^ retard;
  assign mid_phase = sym_phase + 2'd2;

  // External request merged into the slot: an opposite request cancels, and a repeat request overwrites
  always_comb begin
    ext_req = adj_q;
    if (advance && !retard) begin
      ext_req = (adj_q == ADJ_RET) ? ADJ_NONE : ADJ_ADV;
    end else if (retard && !advance) begin
      ext_req = (adj_q == ADJ_ADV) ? ADJ_NONE : ADJ_RET;
    end
  end

  // A strobe consumes the slot; TED requests fill an empty slot only when no external command arrives
  always_comb begin
    adj_d = ext_req;
    apply = ADJ_NONE;
    if (sam_clk_ena) begin
      apply = ext_req;
      adj_d = ADJ_NONE;
    end
    if ((ted_req != ADJ_NONE) && (adj_d == ADJ_NONE) && !ext_cmd) begin
      adj_d = ted_req;
    end
  end

  // Next sampling phase, computed after the decision compare for this strobe
  always_comb begin
    phase_d = sym_phase;
    wrap    = 1'b0;
    case (apply)
      ADJ_ADV: begin
        phase_d = sym_phase + 2'd1;
        wrap    = (sym_phase == 2'd3);
      end
      ADJ_RET: begin
        phase_d = sym_phase - 2'd1;
        wrap    = (sym_phase == 2'd0);
      end
      default: ;
    endcase
  end

  // Decimation datapath, sample counter, and phase register
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      sym_out   <= '0;
      sym_valid <= 1'b0;
      sym_phase <= 2'(PHASE_INIT);
      slip      <= 1'b0;
      sam_cnt   <= 2'd0;
      adj_q     <= ADJ_NONE;
    end else begin
      sym_valid <= decide;
      slip      <= wrap;
      if (decide) sym_out <= sam_in;
      if (sam_clk_ena) sam_cnt <= sam_cnt + 2'd1;
      sym_phase <= phase_d;
      adj_q     <= adj_d;
    end
  end

  // Strobe watchdog: counts cycles without a strobe and saturates at the timeout
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      wd_cnt      <= '0;
      strobe_lost <= 1'b0;
    end else if (sam_clk_ena) begin
      wd_cnt      <= '0;
      strobe_lost <= 1'b0;
    end else if (wd_cnt != WD_MAX) begin
      wd_cnt      <= wd_cnt + 1'b1;
      strobe_lost <= (wd_cnt == WD_LAST);
    end
  end

`ifdef GARDNER_TED_EN
  localparam int PW = 2 * WIDTH + 1;
  localparam logic signed [PW-1:0] E_MAX =
    {{(WIDTH + 2){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [PW-1:0] E_MIN =
    {{(WIDTH + 2){1'b1}}, {(WIDTH - 1){1'b0}}};
  localparam logic signed [ACC_W:0] A_MAX = {2'b00, {(ACC_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] A_MIN = {2'b11, {(ACC_W - 1){1'b0}}};
  localparam logic signed [ACC_W-1:0] THR_P = ACC_W'(TED_THRESH);
  localparam logic signed [ACC_W-1:0] THR_N = -THR_P;

  logic signed [WIDTH-1:0] mid_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [WIDTH:0]   diff;
  logic signed [PW-1:0]    prod;
  logic signed [PW-1:0]    prod_sh;
  logic signed [WIDTH-1:0] e_sat;
  logic signed [ACC_W:0]   acc_sum;
  logic signed [ACC_W-1:0] acc_sat;
  logic                    ted_fire;

  // Gardner error: mid * (previous symbol - current symbol), scaled back to sample range and saturated
  always_comb begin
    diff    = (WIDTH + 1)'(sym_out) - (WIDTH + 1)'(sam_in);
    prod    = PW'(mid_q) * PW'(diff);
    prod_sh = prod >>> (WIDTH - 1);
    if (prod_sh > E_MAX)      e_sat = {1'b0, {(WIDTH - 1){1'b1}}};
    else if (prod_sh < E_MIN) e_sat = {1'b1, {(WIDTH - 1){1'b0}}};
    else                      e_sat = prod_sh[WIDTH-1:0];
    acc_sum = (ACC_W + 1)'(acc_q) + (ACC_W + 1)'(e_sat);
    if (acc_sum > A_MAX)      acc_sat = {1'b0, {(ACC_W - 1){1'b1}}};
    else if (acc_sum < A_MIN) acc_sat = {1'b1, {(ACC_W - 1){1'b0}}};
    else                      acc_sat = acc_sum[ACC_W-1:0];
  end

  // A late timing error builds a positive accumulator, which retards the phase; an early error advances it
  always_comb begin
    ted_req = ADJ_NONE;
    if (decide) begin
      if (acc_sat >= THR_P)      ted_req = ADJ_RET;
      else if (acc_sat <= THR_N) ted_req = ADJ_ADV;
    end
  end

  assign ted_fire = (ted_req != ADJ_NONE);

  // TED state: mid sample, published error, and loop accumulator
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      mid_q   <= '0;
      acc_q   <= '0;
      ted_err <= '0;
    end else begin
      if (sam_clk_ena && (sam_cnt == mid_phase)) mid_q <= sam_in;
      if (decide) begin
        ted_err <= e_sat;
        acc_q   <= ted_fire ? '0 : acc_sat;
      end
    end
  end
`else
  assign ted_req = ADJ_NONE;
  assign ted_err = '0;
`endif

endmodule

// File: tb/tb_sym_phase_align.sv
// Bench for sym_phase_align in its default build (TED disabled).
module tb_sym_phase_align;

  localparam int W  = 18;
  localparam int TO = 8;

  // Clock and reset
  logic                sys_clk = 1'b0;
  logic                reset;
  logic                sam_clk_ena;
  logic signed [W-1:0] sam_in;
  logic                advance;
  logic                retard;
  logic signed [W-1:0] sym_out;
  logic                sym_valid;
  logic [1:0]          sym_phase;
  logic                slip;
  logic                strobe_lost;
  logic signed [W-1:0] ted_err;

  always #5 sys_clk = ~sys_clk;

  sym_phase_align #(
    .WIDTH(W), .PHASE_INIT(0), .STROBE_TIMEOUT(TO), .ACC_W(24), .TED_THRESH(4096)
  ) dut (
    .sys_clk(sys_clk), .reset(reset), .sam_clk_ena(sam_clk_ena), .sam_in(sam_in),
    .advance(advance), .retard(retard), .sym_out(sym_out), .sym_valid(sym_valid),
    .sym_phase(sym_phase), .slip(slip), .strobe_lost(strobe_lost), .ted_err(ted_err)
  );

  // Scoreboard and reference model state
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int m_cnt, m_phase, m_pend, m_wd, ramp;
  logic [W-1:0] m_sym;

  typedef struct {
    logic       adv;
    logic       ret;
    logic [1:0] exp_phase;
    logic       exp_slip;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One sys_clk cycle: drive the inputs, advance the model, then compare after the edge
  task automatic tick(input logic en, input logic [W-1:0] s, input logic adv, input logic ret);
    logic exp_valid;
    logic exp_slip;
    int   np;
    sam_clk_ena = en;
    sam_in      = s;
    advance     = adv;
    retard      = ret;
    if (adv && !ret)      m_pend = (m_pend == -1) ? 0 : 1;
    else if (ret && !adv) m_pend = (m_pend == 1) ? 0 : -1;
    exp_valid = 1'b0;
    exp_slip  = 1'b0;
    if (en) begin
      if (m_cnt == m_phase) begin
        exp_q.push_back(s);
        exp_valid = 1'b1;
      end
      if (m_pend != 0) begin
        np = m_phase + m_pend;
        if (np > 3) begin
          np = 0;
          exp_slip = 1'b1;
        end else if (np < 0) begin
          np = 3;
          exp_slip = 1'b1;
        end
        m_phase = np;
      end
      m_pend = 0;
      m_cnt  = (m_cnt + 1) % 4;
      m_wd   = 0;
    end else if (m_wd < TO) begin
      m_wd++;
    end
    @(posedge sys_clk);
    #1;
    check("sym_valid", sym_valid, exp_valid);
    if (exp_valid) begin
      m_sym = exp_q.pop_front();
      check("sym_out", sym_out, m_sym);
    end else begin
      check("sym_out_hold", sym_out, m_sym);
    end
    if (sym_valid) got_q.push_back(sym_out);
    check("sym_phase", sym_phase, m_phase[1:0]);
    check("slip", slip, exp_slip);
    check("strobe_lost", strobe_lost, (m_wd >= TO));
    check("ted_err", ted_err, 0);
  endtask

  task automatic strobe_period(input logic adv, input logic ret);
    tick(1'b1, W'(ramp), 1'b0, 1'b0);
    ramp++;
    tick(1'b0, '0, adv, ret);
    tick(1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic strobe_only();
    tick(1'b1, W'(ramp), 1'b0, 1'b0);
    ramp++;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    sam_clk_ena = 1'b0;
    sam_in      = '0;
    advance     = 1'b0;
    retard      = 1'b0;
    @(posedge sys_clk);
    #1;
    check("rst_sym_out", sym_out, 0);
    check("rst_sym_valid", sym_valid, 0);
    check("rst_sym_phase", sym_phase, 0);
    check("rst_slip", slip, 0);
    check("rst_strobe_lost", strobe_lost, 0);
    check("rst_ted_err", ted_err, 0);
    reset   = 1'b0;
    m_cnt   = 0;
    m_phase = 0;
    m_pend  = 0;
    m_wd    = 0;
    m_sym   = '0;
    ramp    = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 2'd1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 2'd2, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 2'd3, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 2'd0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 2'd3, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 2'd3, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 2'd2, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 2'd2, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 2'd1, 1'b0};

    reset = 1'b1;
    do_reset();
    do_reset();

    // Ramp stream: advance after the symbol carrying 4 gives 0,4,9,13
    for (int i = 0; i < 16; i++) strobe_period(i == 4, 1'b0);
    check("ramp_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      check("ramp_sym0", got_q[0], 0);
      check("ramp_sym1", got_q[1], 4);
      check("ramp_sym2", got_q[2], 9);
      check("ramp_sym3", got_q[3], 13);
    end
    check("ramp_phase", sym_phase, 1);

    // Phase command table, starting from phase 0
    do_reset();
    for (int v = 0; v < 9; v++) begin
      strobe_period(vecs[v].adv, vecs[v].ret);
      strobe_only();
      check("tbl_phase", sym_phase, vecs[v].exp_phase);
      check("tbl_slip", slip, vecs[v].exp_slip);
      tick(1'b0, '0, 1'b0, 1'b0);
      tick(1'b0, '0, 1'b0, 1'b0);
      tick(1'b0, '0, 1'b0, 1'b0);
      strobe_period(1'b0, 1'b0);
      strobe_period(1'b0, 1'b0);
    end

    // Advance then retard before the strobe cancels: the phase stays at 1
    strobe_only();
    tick(1'b0, '0, 1'b1, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b1);
    tick(1'b0, '0, 1'b0, 1'b0);
    strobe_only();
    check("cancel_phase", sym_phase, 1);
    // Retard twice: the latest wins, so only one step, to 0
    tick(1'b0, '0, 1'b0, 1'b1);
    tick(1'b0, '0, 1'b0, 1'b1);
    tick(1'b0, '0, 1'b0, 1'b0);
    strobe_only();
    check("double_ret_phase", sym_phase, 0);
    for (int i = 0; i < 4; i++) strobe_period(1'b0, 1'b0);

    // Strobes stop for 10 cycles
    strobe_only();
    for (int i = 1; i <= 10; i++) begin
      tick(1'b0, '0, 1'b0, 1'b0);
      if (i == TO - 1) check("lost_before_timeout", strobe_lost, 0);
      if (i == TO)     check("lost_at_timeout", strobe_lost, 1);
    end
    check("lost_held", strobe_lost, 1);
    strobe_only();
    check("lost_cleared", strobe_lost, 0);
    for (int i = 0; i < 8; i++) strobe_period(1'b0, 1'b0);

    // Random gaps and commands, with the scoreboard tracking everything
    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(1, 6);
      strobe_only();
      for (int g = 0; g < gap; g++)
        tick(1'b0, '0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end

    // Reset mid-stream, then resume
    strobe_period(1'b1, 1'b0);
    strobe_only();
    tick(1'b0, '0, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 9; i++) strobe_period(1'b0, 1'b0);
    check("post_reset_count", got_q.size(), 3);
    check("post_reset_last", sym_out, 8);

    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
